lcd_frame_arbiter: RTL and testbench

Shares the 16x2 character LCD between two screen-content clients, such as the title screen and the in-game screen. After reset it runs the LCD power-up command sequence once. It then grants the display to one requesting client at a time, round-robin, and streams that client's 32-character frame as clear, line-1 and line-2 writes. Clients supply characters combinationally against a shared index bus, so they need no LCD timing knowledge.

---
 rtl/lcd_frame_arbiter.sv | 174 +++++++++++++++++
 tb/tb_lcd_frame_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_frame_arbiter.sv
// Shares a 16x2 character LCD between two frame clients: runs the power-up command
// sequence, then grants round-robin and streams clear, line-1 and line-2 writes.
module lcd_frame_arbiter #(
    parameter int unsigned INIT_DELAY = 70,
    parameter int unsigned CMD_HOLD   = 30,
    parameter int unsigned CLEAR_WAIT = 200
) (
    input  logic       CLK,
    input  logic       RESETN,
    input  logic [1:0] REQ,
    input  logic [7:0] CHAR0,
    input  logic [7:0] CHAR1,
    output logic [1:0] GNT,
    output logic [4:0] IDX,
    output logic       BUSY,
    output logic       DONE,
    output logic       LCD_E,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic [7:0] LCD_DATA
);

    localparam int unsigned LINE_LEN = 17;
    localparam int unsigned MAX_AB   = (INIT_DELAY > CMD_HOLD) ? INIT_DELAY : CMD_HOLD;
    localparam int unsigned MAX_ABC  = (MAX_AB > CLEAR_WAIT) ? MAX_AB : CLEAR_WAIT;
    localparam int unsigned MAX_HOLD = (MAX_ABC > LINE_LEN) ? MAX_ABC : LINE_LEN;
    localparam int unsigned CNT_W    = $clog2(MAX_HOLD);

    typedef enum logic [3:0] {
        INIT_WAIT,
        FUNC_SET,
        DISP_ON,
        ENTRY,
        IDLE,
        CLEAR,
        LINE1,
        LINE2,
        FIN
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             last;
    logic             cnt_end_c;
    logic             win_c;
    logic [7:0]       gnt_char_c;

    assign LCD_E      = CLK;
    assign gnt_char_c = GNT[1] ? CHAR1 : CHAR0;

    // Round-robin: on a tie the client that was not served last wins.
    always_comb begin
        win_c = (REQ == 2'b11) ? ~last : REQ[1];
    end

    // Final cycle of the current state's hold period.
    always_comb begin
        cnt_end_c = 1'b0;
        case (state)
            INIT_WAIT:               cnt_end_c = (cnt == CNT_W'(INIT_DELAY - 1));
            FUNC_SET, DISP_ON, ENTRY: cnt_end_c = (cnt == CNT_W'(CMD_HOLD - 1));
            CLEAR:                   cnt_end_c = (cnt == CNT_W'(CLEAR_WAIT - 1));
            LINE1, LINE2:            cnt_end_c = (cnt == CNT_W'(LINE_LEN - 1));
            default:                 cnt_end_c = 1'b0;
        endcase
    end

    // Index leads the registered data byte by one cycle.
    always_comb begin
        IDX = 5'd0;
        if (state == LINE1 && cnt != '0) begin
            IDX = 5'(cnt - CNT_W'(1));
        end else if (state == LINE2) begin
            IDX = 5'(cnt + CNT_W'(15));
        end
    end

    always_ff @(posedge CLK or posedge RESETN) begin
        if (RESETN) begin
            state    <= INIT_WAIT;
            cnt      <= '0;
            last     <= 1'b1;
            GNT      <= 2'b00;
            DONE     <= 1'b0;
            BUSY     <= 1'b1;
            LCD_RS   <= 1'b0;
            LCD_RW   <= 1'b1;
            LCD_DATA <= 8'h00;
        end else begin
            DONE     <= 1'b0;
            cnt      <= cnt + CNT_W'(1);
            LCD_RS   <= 1'b0;
            LCD_RW   <= 1'b0;
            LCD_DATA <= 8'h00;
            case (state)
                INIT_WAIT: begin
                    LCD_RW <= 1'b1;
                    if (cnt_end_c) begin
                        state <= FUNC_SET;
                        cnt   <= '0;
                    end
                end
                FUNC_SET: begin
                    LCD_DATA <= 8'h3C;
                    if (cnt_end_c) begin
                        state <= DISP_ON;
                        cnt   <= '0;
                    end
                end
                DISP_ON: begin
                    LCD_DATA <= 8'h0C;
                    if (cnt_end_c) begin
                        state <= ENTRY;
                        cnt   <= '0;
                    end
                end
                ENTRY: begin
                    LCD_DATA <= 8'h06;
                    if (cnt_end_c) begin
                        state <= IDLE;
                        cnt   <= '0;
                        BUSY  <= 1'b0;
                    end
                end
                IDLE: begin
                    LCD_RW <= 1'b1;
                    cnt    <= '0;
                    if (REQ != 2'b00) begin
                        state <= CLEAR;
                        GNT   <= win_c ? 2'b10 : 2'b01;
                        last  <= win_c;
                        BUSY  <= 1'b1;
                    end
                end
                CLEAR: begin
                    LCD_DATA <= 8'h01;
                    if (cnt_end_c) begin
                        state <= LINE1;
                        cnt   <= '0;
                    end
                end
                LINE1, LINE2: begin
                    if (cnt == '0) begin
                        LCD_DATA <= (state == LINE1) ? 8'h80 : 8'hC0;
                    end else begin
                        LCD_RS   <= 1'b1;
                        LCD_DATA <= gnt_char_c;
                    end
                    if (cnt_end_c) begin
                        cnt <= '0;
                        if (state == LINE1) begin
                            state <= LINE2;
                        end else begin
                            state <= FIN;
                            DONE  <= 1'b1;
                        end
                    end
                end
                FIN: begin
                    LCD_RW <= 1'b1;
                    state  <= IDLE;
                    cnt    <= '0;
                    GNT    <= 2'b00;
                    BUSY   <= 1'b0;
                end
                default: begin
                    state <= INIT_WAIT;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_frame_arbiter.sv
// Bench for lcd_frame_arbiter: random client frames and request patterns checked
// against a cycle-indexed model of the expected LCD byte stream and grants.
module tb_lcd_frame_arbiter;

    localparam int INIT_DELAY = 70;
    localparam int CMD_HOLD   = 30;
    localparam int CLEAR_WAIT = 200;
    localparam int INIT_LEN   = INIT_DELAY + 3 * CMD_HOLD;
    localparam int FRAME_LEN  = CLEAR_WAIT + 35;

    logic       CLK;
    logic       RESETN;
    logic [1:0] REQ;
    logic [7:0] CHAR0;
    logic [7:0] CHAR1;
    logic [1:0] GNT;
    logic [4:0] IDX;
    logic       BUSY;
    logic       DONE;
    logic       LCD_E;
    logic       LCD_RS;
    logic       LCD_RW;
    logic [7:0] LCD_DATA;

    int   checks = 0;
    int   errors = 0;
    logic [7:0] tab0 [32];
    logic [7:0] tab1 [32];
    bit   ascii_mode;
    int   last_m;

    lcd_frame_arbiter #(
        .INIT_DELAY(INIT_DELAY),
        .CMD_HOLD  (CMD_HOLD),
        .CLEAR_WAIT(CLEAR_WAIT)
    ) dut (
        .CLK     (CLK),
        .RESETN  (RESETN),
        .REQ     (REQ),
        .CHAR0   (CHAR0),
        .CHAR1   (CHAR1),
        .GNT     (GNT),
        .IDX     (IDX),
        .BUSY    (BUSY),
        .DONE    (DONE),
        .LCD_E   (LCD_E),
        .LCD_RS  (LCD_RS),
        .LCD_RW  (LCD_RW),
        .LCD_DATA(LCD_DATA)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Clients answer the index bus combinationally.
    assign CHAR0 = ascii_mode ? 8'(8'h41 + IDX) : tab0[IDX];
    assign CHAR1 = ascii_mode ? 8'(8'h61 + IDX) : tab1[IDX];

    function automatic logic [7:0] exp_char(input int client, input int i);
        if (ascii_mode) return (client == 1) ? 8'(8'h61 + i) : 8'(8'h41 + i);
        return (client == 1) ? tab1[i] : tab0[i];
    endfunction

    // {RS, RW, DATA} seen during cycle k after reset release.
    function automatic logic [9:0] exp_init_bus(input int k);
        int m;
        if (k <= INIT_DELAY || k > INIT_LEN) return {2'b01, 8'h00};
        m = (k - INIT_DELAY - 1) / CMD_HOLD;
        case (m)
            0:       return {2'b00, 8'h3C};
            1:       return {2'b00, 8'h0C};
            default: return {2'b00, 8'h06};
        endcase
    endfunction

    // {RS, RW, DATA} seen j cycles after the grant edge: one-cycle-late byte stream.
    function automatic logic [9:0] exp_frame_bus(input int j, input int client);
        int n;
        if (j <= 0 || j >= FRAME_LEN) return {2'b01, 8'h00};
        n = j - 1;
        if (n < CLEAR_WAIT) return {2'b00, 8'h01};
        n = n - CLEAR_WAIT;
        if (n == 0) return {2'b00, 8'h80};
        if (n <= 16) return {2'b10, exp_char(client, n - 1)};
        if (n == 17) return {2'b00, 8'hC0};
        return {2'b10, exp_char(client, n - 2)};
    endfunction

    function automatic int model_pick(input logic [1:0] req);
        if (req == 2'b11) return (last_m == 1) ? 0 : 1;
        return req[1] ? 1 : 0;
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic randomize_tabs();
        for (int i = 0; i < 32; i++) begin
            tab0[i] = 8'($urandom);
            tab1[i] = 8'($urandom);
        end
    endtask

    task automatic apply_reset();
        RESETN = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        RESETN = 1'b0;
        last_m = 1;
    endtask

    // Checks cycles 0..INIT_LEN after reset release; ends sampling the first IDLE cycle.
    task automatic run_init(input int req_at, input logic [1:0] req_val);
        logic [9:0] bus;
        for (int k = 0; k <= INIT_LEN; k++) begin
            if (k == req_at) REQ = req_val;
            bus = exp_init_bus(k);
            checks++;
            if ({LCD_RS, LCD_RW, LCD_DATA} !== bus) begin
                errors++;
                $display("FAIL init_bus k=%0d got %h expected %h", k, {LCD_RS, LCD_RW, LCD_DATA}, bus);
            end
            checks++;
            if (GNT !== 2'b00 || DONE !== 1'b0) begin
                errors++;
                $display("FAIL init_gnt k=%0d got gnt=%b done=%b expected gnt=00 done=0", k, GNT, DONE);
            end
            checks++;
            if (BUSY !== (k < INIT_LEN)) begin
                errors++;
                $display("FAIL init_busy k=%0d got %b expected %b", k, BUSY, (k < INIT_LEN));
            end
            if (k < INIT_LEN) step();
        end
    endtask

    // Call during an IDLE sample with REQ already applied; ends on the following IDLE sample.
    task automatic expect_frame(input int client, input int drop_j, input int abort_j);
        logic [1:0] g;
        logic [9:0] bus;
        step();
        for (int j = 0; j <= FRAME_LEN; j++) begin
            if (j == abort_j) return;
            g = (j < FRAME_LEN) ? ((client == 1) ? 2'b10 : 2'b01) : 2'b00;
            checks++;
            if (GNT !== g) begin
                errors++;
                $display("FAIL frame_gnt j=%0d got %b expected %b", j, GNT, g);
            end
            checks++;
            if (DONE !== (j == FRAME_LEN - 1)) begin
                errors++;
                $display("FAIL frame_done j=%0d got %b expected %b", j, DONE, (j == FRAME_LEN - 1));
            end
            checks++;
            if (BUSY !== (j < FRAME_LEN)) begin
                errors++;
                $display("FAIL frame_busy j=%0d got %b expected %b", j, BUSY, (j < FRAME_LEN));
            end
            bus = exp_frame_bus(j, client);
            checks++;
            if ({LCD_RS, LCD_RW, LCD_DATA} !== bus) begin
                errors++;
                $display("FAIL frame_bus j=%0d got %h expected %h", j, {LCD_RS, LCD_RW, LCD_DATA}, bus);
            end
            if (j == drop_j) REQ = 2'b00;
            if (j < FRAME_LEN) step();
        end
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({GNT, DONE, BUSY, LCD_RS, LCD_RW, LCD_DATA, IDX} !== {2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 5'd0}) begin
            errors++;
            $display("FAIL reset_values got gnt=%b done=%b busy=%b rs=%b rw=%b data=%h idx=%0d expected 00 0 1 0 1 00 0",
                     GNT, DONE, BUSY, LCD_RS, LCD_RW, LCD_DATA, IDX);
        end
        checks++;
        if (LCD_E !== 1'b1) begin
            errors++;
            $display("FAIL lcd_e_follows_clk got %b expected 1", LCD_E);
        end
        run_init(-1, 2'b00);
    endtask

    task automatic test_single();
        int c;
        ascii_mode = 1'b1;
        REQ = 2'b01;
        c = model_pick(REQ);
        last_m = c;
        expect_frame(c, FRAME_LEN - 1, -1);
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (GNT !== 2'b00 || BUSY !== 1'b0) begin
                errors++;
                $display("FAIL single_idle i=%0d got gnt=%b busy=%b expected 00 0", i, GNT, BUSY);
            end
        end
    endtask

    task automatic test_back_to_back();
        int c;
        int prev;
        ascii_mode = 1'b0;
        randomize_tabs();
        REQ = 2'b11;
        prev = -1;
        for (int f = 0; f < 3; f++) begin
            c = model_pick(2'b11);
            last_m = c;
            checks++;
            if (c == prev) begin
                errors++;
                $display("FAIL b2b_alternate f=%0d got client %0d expected other than %0d", f, c, prev);
            end
            prev = c;
            expect_frame(c, (f == 2) ? FRAME_LEN - 1 : -1, -1);
        end
    endtask

    task automatic test_drop();
        int c;
        randomize_tabs();
        REQ = 2'b01;
        c = model_pick(REQ);
        last_m = c;
        expect_frame(c, CLEAR_WAIT + 5, -1);
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (GNT !== 2'b00 || BUSY !== 1'b0) begin
                errors++;
                $display("FAIL drop_no_regrant i=%0d got gnt=%b busy=%b expected 00 0", i, GNT, BUSY);
            end
        end
    endtask

    task automatic test_random();
        int c;
        int gap;
        logic [1:0] r;
        ascii_mode = 1'b0;
        for (int it = 0; it < 12; it++) begin
            randomize_tabs();
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                step();
                checks++;
                if (GNT !== 2'b00 || BUSY !== 1'b0) begin
                    errors++;
                    $display("FAIL rand_idle it=%0d got gnt=%b busy=%b expected 00 0", it, GNT, BUSY);
                end
            end
            r = 2'($urandom_range(0, 3));
            REQ = r;
            if (r == 2'b00) begin
                step();
                checks++;
                if (GNT !== 2'b00) begin
                    errors++;
                    $display("FAIL rand_no_req it=%0d got %b expected 00", it, GNT);
                end
            end else begin
                c = model_pick(r);
                last_m = c;
                expect_frame(c, ($urandom_range(0, 1) == 0) ? FRAME_LEN - 1 : $urandom_range(1, FRAME_LEN - 1), -1);
            end
        end
    endtask

    task automatic test_req_during_init();
        int c;
        REQ = 2'b00;
        randomize_tabs();
        apply_reset();
        run_init(20, 2'b10);
        c = model_pick(REQ);
        last_m = c;
        expect_frame(c, FRAME_LEN - 1, -1);
    endtask

    task automatic test_mid_reset();
        int c;
        randomize_tabs();
        REQ = 2'b01;
        c = model_pick(REQ);
        last_m = c;
        expect_frame(c, -1, CLEAR_WAIT + 26);
        #2;
        RESETN = 1'b1;
        #1;
        checks++;
        if ({GNT, DONE, BUSY, LCD_RS, LCD_RW, LCD_DATA} !== {2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00}) begin
            errors++;
            $display("FAIL async_reset got gnt=%b done=%b busy=%b rs=%b rw=%b data=%h expected 00 0 1 0 1 00",
                     GNT, DONE, BUSY, LCD_RS, LCD_RW, LCD_DATA);
        end
        @(posedge CLK);
        #1;
        RESETN = 1'b0;
        last_m = 1;
        run_init(-1, 2'b00);
        c = model_pick(REQ);
        last_m = c;
        expect_frame(c, FRAME_LEN - 1, -1);
    endtask

    initial begin
        RESETN     = 1'b0;
        REQ        = 2'b00;
        ascii_mode = 1'b0;
        last_m     = 1;
        randomize_tabs();
        test_reset();
        test_single();
        test_back_to_back();
        test_drop();
        test_random();
        test_req_during_init();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
